// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: the in-order pipe has priority, long-latency results queue up,
// and a starvation guard forces the queue head out. Optional direct lu path: RF_WB_LU_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int REG_WIDTH  = 32,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            pipe_valid,
  output logic                            pipe_ready,
  input  logic [4:0]                      pipe_rd,
  input  logic [REG_WIDTH-1:0]            pipe_data,
  input  logic                            lu_valid,
  output logic                            lu_ready,
  input  logic [4:0]                      lu_rd,
  input  logic [REG_WIDTH-1:0]            lu_data,
  output logic [4:0]                      rd,
  output logic [REG_WIDTH-1:0]            rd_din,
  output logic                            reg_write,
  output logic [$clog2(LQ_DEPTH+1)-1:0]   pending_cnt
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  function automatic logic [SW-1:0] starve_sat_inc(input logic [SW-1:0] cur);
    return (cur == SW'(STARVE_MAX)) ? cur : cur + SW'(1);
  endfunction

  logic [4:0]           lq_rd   [LQ_DEPTH];
  logic [REG_WIDTH-1:0] lq_data [LQ_DEPTH];
  logic [PW-1:0]        head_p0, tail_p0;
  logic [CW-1:0]        count_p0;
  logic [SW-1:0]        starve_p0;

  logic                 q_empty_p0, force_p0, pipe_eff_p0, lu_hs_p0;
  logic                 grant_pipe_p0, grant_q_p0, enq_p0, bypass_p0;

  logic                 vld_p1;
  logic [4:0]           rd_p1;
  logic [REG_WIDTH-1:0] data_p1;

  // Stage p0: grant decision from registered queue state
  assign q_empty_p0    = (count_p0 == '0);
  assign force_p0      = (starve_p0 == SW'(STARVE_MAX)) && !q_empty_p0;
  assign pipe_eff_p0   = pipe_valid && (pipe_rd != 5'd0);
  assign grant_pipe_p0 = pipe_eff_p0 && !force_p0;
  assign grant_q_p0    = !q_empty_p0 && (force_p0 || !pipe_eff_p0);
  assign pipe_ready    = !force_p0;
  assign lu_ready      = (count_p0 != CW'(LQ_DEPTH));
  assign lu_hs_p0      = lu_valid && lu_ready && (lu_rd != 5'd0);

`ifdef RF_WB_LU_BYPASS_EN
  assign bypass_p0 = q_empty_p0 && !grant_pipe_p0 && lu_hs_p0;
`else
  assign bypass_p0 = 1'b0;
`endif

  assign enq_p0 = lu_hs_p0 && !bypass_p0;

  always_ff @(posedge clk) begin
    if (enq_p0) begin
      lq_rd[tail_p0]   <= lu_rd;
      lq_data[tail_p0] <= lu_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_p0   <= '0;
      tail_p0   <= '0;
      count_p0  <= '0;
      starve_p0 <= '0;
    end else begin
      if (enq_p0)
        tail_p0 <= tail_p0 + PW'(1);
      if (grant_q_p0)
        head_p0 <= head_p0 + PW'(1);
      case ({enq_p0, grant_q_p0})
        2'b10:   count_p0 <= count_p0 + CW'(1);
        2'b01:   count_p0 <= count_p0 - CW'(1);
        default: count_p0 <= count_p0;
      endcase
      if (q_empty_p0 || grant_q_p0)
        starve_p0 <= '0;
      else
        starve_p0 <= starve_sat_inc(starve_p0);
    end
  end

  // Stage p1: registered write port, rd/rd_din hold when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else if (grant_pipe_p0) begin
      vld_p1  <= 1'b1;
      rd_p1   <= pipe_rd;
      data_p1 <= pipe_data;
    end else if (grant_q_p0) begin
      vld_p1  <= 1'b1;
      rd_p1   <= lq_rd[head_p0];
      data_p1 <= lq_data[head_p0];
    end else if (bypass_p0) begin
      vld_p1  <= 1'b1;
      rd_p1   <= lu_rd;
      data_p1 <= lu_data;
    end else begin
      vld_p1  <= 1'b0;
    end
  end

  assign reg_write   = vld_p1;
  assign rd          = rd_p1;
  assign rd_din      = data_p1;
  assign pending_cnt = count_p0;

endmodule
